memwrite_monitor: RTL
=====================

# memwrite_monitor

Synthesizable, parametrised checker for the processor's data-memory write port, replacing hard-coded pass/fail bench logic. Holds a programmable table of expected writes and tolerated scratch addresses, watches `memwrite`/`dataadr`/`writedata` every cycle, and issues a registered verdict (pass, data mismatch, unexpected address, timeout). Sits beside `top` in benches and on FPGA self-test builds.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `DEPTH`, 4, table entries (≥1)
- `ORDERED`, 1, 1 = expected writes must occur in table index order; 0 = any order
- `TIMEOUT`, 1000, cycles in ARMED before timeout fail (≥1)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state including table
- `cfg_we`  in  1  table write strobe
- `cfg_idx`  in  $clog2(DEPTH)  entry index
- `cfg_kind`  in  2  0 = invalid, 1 = expected, 2 = ignore (tolerated address), 3 = reserved (treated as invalid)
- `cfg_addr`  in  ADDR_W  entry address
- `cfg_data`  in  DATA_W  entry data (unused for ignore)
- `start`  in  1  arm the monitor
- `memwrite`  in  1  observed write enable
- `dataadr`  in  ADDR_W  observed address
- `writedata`  in  DATA_W  observed data
- `done`  out  1  verdict available (PASS or FAIL state)
- `pass`  out  1  verdict is pass
- `fail_code`  out  2  0 none, 1 data mismatch, 2 unexpected address, 3 timeout
- `fail_addr`  out  ADDR_W  `dataadr` of offending write (0 for timeout)
- `fail_data`  out  DATA_W  `writedata` of offending write (0 for timeout)
- `match_count`  out  $clog2(DEPTH+1)  expected entries matched so far
- `cycle_count`  out  $clog2(TIMEOUT+1)  cycles spent in ARMED

## Operation
- States: IDLE → ARMED (on `start`) → PASS or FAIL; `start` in PASS/FAIL re-arms; `start` in ARMED ignored.
- Arming clears matched mask, `match_count`, `cycle_count`, `fail_*`; table retained.
- `cfg_we` accepted only in IDLE/PASS/FAIL; ignored in ARMED.
- Arming with zero expected entries: PASS on next edge.
- Each ARMED cycle with `memwrite`=1, evaluate in priority order:
  - ORDERED=1: head = lowest-index unmatched expected entry. addr & data equal head → mark matched. Addr equal head, data differ → FAIL code 1. Else addr equals any ignore entry → no effect. Else FAIL code 2.
  - ORDERED=0: addr & data equal any unmatched expected entry → mark lowest such index. Else addr equals an unmatched expected entry's addr → FAIL code 1. Else ignore hit → no effect. Else FAIL code 2 (includes repeat write to an already-matched address not also listed as ignore).
- All expected entries matched → PASS (same edge as final match).
- `cycle_count` increments each ARMED cycle, saturates; reaching TIMEOUT with no verdict → FAIL code 3. A write evaluated on the timeout edge takes precedence over timeout.
- `memwrite`=0 cycles and writes outside ARMED are never evaluated.
- Duplicate table entries allowed; lowest index wins.

## Timing
- Reset values: all outputs 0, state IDLE, all entries invalid.
- `memwrite` sampled at rising edge N; verdict/`match_count` updated at edge N (visible after N), i.e. one-cycle registered latency; no combinational input→output path.
- `start` at edge N → ARMED after N; first write evaluated at edge N+1.
- `cfg_we` at edge N → entry usable if armed at N+1 or later.
- `done`/`pass`/`fail_*` hold until re-arm or reset.
- Reset asserted mid-ARMED: immediate return to IDLE, verdict lost, table cleared.

## Structure
- Package `mon_pkg`: state encoding (IDLE, ARMED, PASS, FAIL), fail-code constants, cfg_kind constants.
- Sub-module `monitor_entry_table`: DEPTH-entry register file plus parallel address/data comparators, outputs per-entry hit vectors (`exp_full_hit`, `exp_addr_hit`, `ign_hit`); top holds FSM, matched mask, counters, priority logic.

## Test plan
- ORDERED=1, entry0 expected (84,7), entry1 ignore 80; writes (80,x),(80,y),(84,7) → PASS after third write, `match_count`=1, `fail_code`=0.
- Same table, write (84,6) → FAIL code 1, `fail_addr`=84, `fail_data`=6; write (96,7) after re-arm → FAIL code 2.
- ORDERED=1, expected (0,1),(4,2); writes (4,2) then (0,1) → FAIL code 2 on first; ORDERED=0 same stimulus → PASS, `match_count`=2.
- TIMEOUT=20, expected (84,7), no writes → FAIL code 3 at `cycle_count`=20; write (84,7) exactly on timeout edge → PASS instead.
- Reset pulse during ARMED after one match → outputs 0, IDLE, table invalid; `start` with empty table → PASS next cycle.
- `cfg_we` during ARMED changing entry0 to (84,8) ignored → (84,7) still passes; re-arm after PASS reproduces PASS with cleared counters.

Source files
------------

// File: rtl/memwrite_monitor_pkg.sv
// Shared types for the data-memory write monitor: FSM states, verdict codes,
// table entry kinds and width helpers.
package mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_DATA    = 2'd1,
    FAIL_ADDR    = 2'd2,
    FAIL_TIMEOUT = 2'd3
  } fail_code_e;

  typedef enum logic [1:0] {
    KIND_INVALID  = 2'd0,
    KIND_EXPECT   = 2'd1,
    KIND_IGNORE   = 2'd2,
    KIND_RESERVED = 2'd3
  } cfg_kind_e;

  // A single-entry table still needs a one-bit index port.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int maxval);
    return (maxval > 0) ? $clog2(maxval + 1) : 1;
  endfunction

endpackage

// File: rtl/memwrite_monitor_if.sv
// Configuration, observed write port and verdict bundle of memwrite_monitor.
interface memwrite_monitor_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000
);
  import mon_pkg::*;

  localparam int IDX_W = idx_width(DEPTH);
  localparam int MC_W  = count_width(DEPTH);
  localparam int CC_W  = count_width(TIMEOUT);

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [1:0]        cfg_kind;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              start;
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;
  logic              done;
  logic              pass;
  logic [1:0]        fail_code;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic [MC_W-1:0]   match_count;
  logic [CC_W-1:0]   cycle_count;

  modport master (
    output cfg_we, cfg_idx, cfg_kind, cfg_addr, cfg_data, start,
    output memwrite, dataadr, writedata,
    input  done, pass, fail_code, fail_addr, fail_data, match_count, cycle_count
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_kind, cfg_addr, cfg_data, start,
    input  memwrite, dataadr, writedata,
    output done, pass, fail_code, fail_addr, fail_data, match_count, cycle_count
  );

endinterface

// File: rtl/memwrite_monitor_entry_table.sv
// Programmable table of expected/ignored writes with one address and data
// comparator per entry; produces per-entry hit vectors for the observed write.
module monitor_entry_table
  import mon_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [1:0]        cfg_kind,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [ADDR_W-1:0] obs_addr,
  input  logic [DATA_W-1:0] obs_data,
  output logic [DEPTH-1:0]  exp_valid,
  output logic [DEPTH-1:0]  exp_full_hit,
  output logic [DEPTH-1:0]  exp_addr_hit,
  output logic [DEPTH-1:0]  ign_hit
);

  localparam int unsigned NENT = DEPTH;

  cfg_kind_e         kind_q [NENT];
  logic [ADDR_W-1:0] addr_q [NENT];
  logic [DATA_W-1:0] data_q [NENT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NENT; i++) begin
        kind_q[i] <= KIND_INVALID;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < NENT; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          kind_q[i] <= cfg_kind_e'(cfg_kind);
          addr_q[i] <= cfg_addr;
          data_q[i] <= cfg_data;
        end
      end
    end
  end

  // Reserved kinds never match, so they behave exactly like invalid entries.
  always_comb begin
    exp_valid    = '0;
    exp_full_hit = '0;
    exp_addr_hit = '0;
    ign_hit      = '0;
    for (int unsigned i = 0; i < NENT; i++) begin
      exp_valid[i]    = (kind_q[i] == KIND_EXPECT);
      exp_addr_hit[i] = (kind_q[i] == KIND_EXPECT) && (addr_q[i] == obs_addr);
      exp_full_hit[i] = exp_addr_hit[i] && (data_q[i] == obs_data);
      ign_hit[i]      = (kind_q[i] == KIND_IGNORE) && (addr_q[i] == obs_addr);
    end
  end

endmodule

// File: rtl/memwrite_monitor.sv
// Data-memory write checker: compares observed writes against a programmed
// table and latches a registered pass / fail verdict.
module memwrite_monitor
  import mon_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int ORDERED = 1,
  parameter int TIMEOUT = 1000
) (
  input logic               clk,
  input logic               reset,
  memwrite_monitor_if.slave mon
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int MC_W  = count_width(DEPTH);
  localparam int CC_W  = count_width(TIMEOUT);

  mon_state_e        state_q;
  logic [DEPTH-1:0]  matched_q;
  logic              done_q;
  logic              pass_q;
  fail_code_e        fail_code_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic [MC_W-1:0]   match_count_q;
  logic [CC_W-1:0]   cycle_count_q;

  logic [DEPTH-1:0]  exp_valid;
  logic [DEPTH-1:0]  exp_full_hit;
  logic [DEPTH-1:0]  exp_addr_hit;
  logic [DEPTH-1:0]  ign_hit;
  logic [DEPTH-1:0]  unmatched;
  logic [DEPTH-1:0]  head;
  logic [DEPTH-1:0]  cand;
  logic [DEPTH-1:0]  mark;
  logic              wr_fail;
  fail_code_e        wr_code;
  logic              cfg_allow;
  logic              timeout_edge;
  logic              arm;

  assign cfg_allow    = mon.cfg_we && (state_q != ST_ARMED);
  assign timeout_edge = (cycle_count_q == CC_W'(TIMEOUT - 1));
  assign arm          = mon.start && (state_q != ST_ARMED);

  monitor_entry_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_allow),
    .cfg_idx      (mon.cfg_idx),
    .cfg_kind     (mon.cfg_kind),
    .cfg_addr     (mon.cfg_addr),
    .cfg_data     (mon.cfg_data),
    .obs_addr     (mon.dataadr),
    .obs_data     (mon.writedata),
    .exp_valid    (exp_valid),
    .exp_full_hit (exp_full_hit),
    .exp_addr_hit (exp_addr_hit),
    .ign_hit      (ign_hit)
  );

  // x & (~x + 1) isolates the lowest set bit, giving lowest-index-wins.
  always_comb begin
    unmatched = exp_valid & ~matched_q;
    head      = '0;
    cand      = '0;
    mark      = '0;
    wr_fail   = 1'b0;
    wr_code   = FAIL_NONE;
    if (ORDERED != 0) begin
      head = unmatched & (~unmatched + DEPTH'(1));
      if (|(head & exp_full_hit)) begin
        mark = head;
      end else if (|(head & exp_addr_hit)) begin
        wr_fail = 1'b1;
        wr_code = FAIL_DATA;
      end else if (!(|ign_hit)) begin
        wr_fail = 1'b1;
        wr_code = FAIL_ADDR;
      end
    end else begin
      cand = unmatched & exp_full_hit;
      if (|cand) begin
        mark = cand & (~cand + DEPTH'(1));
      end else if (|(unmatched & exp_addr_hit)) begin
        wr_fail = 1'b1;
        wr_code = FAIL_DATA;
      end else if (!(|ign_hit)) begin
        wr_fail = 1'b1;
        wr_code = FAIL_ADDR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      matched_q     <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= FAIL_NONE;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
      match_count_q <= '0;
      cycle_count_q <= '0;
    end else if (arm) begin
      state_q       <= ST_ARMED;
      matched_q     <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= FAIL_NONE;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
      match_count_q <= '0;
      cycle_count_q <= '0;
    end else if (state_q == ST_ARMED) begin
      if (cycle_count_q < CC_W'(TIMEOUT)) begin
        cycle_count_q <= cycle_count_q + CC_W'(1);
      end
      // A verdict from the write beats a timeout landing on the same edge.
      if (unmatched == '0) begin
        state_q <= ST_PASS;
        done_q  <= 1'b1;
        pass_q  <= 1'b1;
      end else if (mon.memwrite && wr_fail) begin
        state_q     <= ST_FAIL;
        done_q      <= 1'b1;
        fail_code_q <= wr_code;
        fail_addr_q <= mon.dataadr;
        fail_data_q <= mon.writedata;
      end else if (mon.memwrite && (|mark)) begin
        matched_q     <= matched_q | mark;
        match_count_q <= match_count_q + MC_W'(1);
        if ((unmatched & ~mark) == '0) begin
          state_q <= ST_PASS;
          done_q  <= 1'b1;
          pass_q  <= 1'b1;
        end else if (timeout_edge) begin
          state_q     <= ST_FAIL;
          done_q      <= 1'b1;
          fail_code_q <= FAIL_TIMEOUT;
        end
      end else if (timeout_edge) begin
        state_q     <= ST_FAIL;
        done_q      <= 1'b1;
        fail_code_q <= FAIL_TIMEOUT;
      end
    end
  end

  assign mon.done        = done_q;
  assign mon.pass        = pass_q;
  assign mon.fail_code   = fail_code_q;
  assign mon.fail_addr   = fail_addr_q;
  assign mon.fail_data   = fail_data_q;
  assign mon.match_count = match_count_q;
  assign mon.cycle_count = cycle_count_q;

endmodule
